tile_batch_scheduler: RTL and testbench
=======================================

Name: tile_batch_scheduler

Overview:
Sequences the transpose-convolution compute engine tile by tile. Tiles are grouped into batches of TILES_PER_BATCH. At each batch boundary the block raises the batch_complete or all_batches_complete trigger for the output stream manager, and it interlocks against the stream manager's transmission_active so that no trigger is lost and no tile starts while output BRAMs are being streamed. It sits between the top-level control (PS start) and both the compute engine and the output stream manager.

Parameters:
TILES_PER_BATCH, 4, tiles per batch (>=1)
NUM_BATCHES, 8, batches per run (>=1)
BATCH_ID_W, 3, width of batch id (>= clog2(NUM_BATCHES))
TILE_ID_W, 5, width of global tile index (>= clog2(TILES_PER_BATCH*NUM_BATCHES))

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  level/pulse; begins a run when sampled high in IDLE
tile_done  in  1  one-cycle pulse from compute engine: current tile finished
stream_busy  in  1  transmission_active from output stream manager
tile_start  out  1  one-cycle pulse: compute engine begins tile tile_id
tile_id  out  TILE_ID_W  global index of current tile (batch*TILES_PER_BATCH + tile_in_batch)
batch_complete  out  1  one-cycle pulse: a non-final batch finished
completed_batch_id  out  BATCH_ID_W  batch id qualified by batch_complete/all_batches_complete, held until the next pulse
all_batches_complete  out  1  one-cycle pulse: final batch finished
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the run and the final stream finish
err_spurious  out  1  sticky: tile_done seen outside WAIT_TILE; cleared on accepted start
state_debug  out  3  current FSM state encoding

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0; tile_in_batch and batch_cnt are 0. Reset mid-run aborts immediately and emits no pulses.
- All outputs are registered. Pulses are high for exactly one cycle.
- States and transitions:
  - IDLE(0): start=1 -> ISSUE. Clear counters, tile_id and err_spurious.
  - ISSUE(1): if stream_busy=1, stay (stall). Otherwise set tile_start<=1 and go to WAIT_TILE.
  - WAIT_TILE(2): on tile_done=1:
    - if tile_in_batch==TILES_PER_BATCH-1 -> BATCH_END;
    - otherwise tile_in_batch++, tile_id++, -> ISSUE.
  - BATCH_END(3): wait for stream_busy=0 (the stream manager only samples triggers in its IDLE). Then set completed_batch_id<=batch_cnt.
    - If batch_cnt==NUM_BATCHES-1: all_batches_complete<=1 (batch_complete stays 0) -> GUARD_FINAL.
    - Otherwise: batch_complete<=1 -> GUARD.
  - GUARD(4): one cycle, covering the stream manager's one-cycle delay before it raises stream_busy. Then batch_cnt++, tile_in_batch<=0, tile_id++ -> ISSUE. ISSUE then stalls until the notification finishes.
  - GUARD_FINAL(5): one cycle -> WAIT_FINAL.
  - WAIT_FINAL(6): when stream_busy=0, set done<=1 -> IDLE.
- Latency, no stalls:
  - start sampled at edge E0 -> tile_start high after E1.
  - tile_done sampled at edge Ek -> next tile_start high after Ek+1.
  - If that tile_done ends a batch: batch trigger high after Ek+1.
- start while busy: ignored.
- tile_done outside WAIT_TILE: ignored, and err_spurious is set.
- tile_done coinciding with a start in IDLE: start is taken, tile_done is flagged spurious, and err_spurious stays set for this run.
- Counters never wrap within a run. The final tile_id is TILES_PER_BATCH*NUM_BATCHES-1.

Test Plan:
- Nominal run, defaults, stream_busy tied low, tile_done 3 cycles after each tile_start -> 32 tile_start pulses (tile_id 0..31); 7 batch_complete pulses with completed_batch_id 0..6; one all_batches_complete with id 7 and no batch_complete alongside it; done 2 cycles later; busy low after done.
- Stream interlock: after batch 0 trigger, model stream_busy high for 6 cycles starting the cycle after the pulse -> tile_start for tile 4 appears only the cycle after stream_busy falls.
- Trigger hold-off: stream_busy high when tile 3 finishes -> no batch_complete until stream_busy low; then exactly one pulse, with id 0.
- Final stream: stream_busy high 100 cycles after all_batches_complete -> done asserts exactly 1 cycle after stream_busy falls; busy stays high throughout.
- Spurious/ignored inputs: tile_done in ISSUE, and start during WAIT_TILE -> err_spurious=1, tile_id unchanged, no extra tile_start; next accepted start clears err_spurious.
- Reset mid-run: assert rst_n=0 during batch 2 WAIT_TILE -> all outputs 0 asynchronously, state_debug=0; a fresh start restarts at tile_id 0 with batch id 0.

Source files
------------

// File: rtl/tile_batch_scheduler.sv
// Tile/batch sequencer for the transpose-convolution engine: issues tiles, raises
// per-batch stream triggers and interlocks against the output stream manager.
module tile_batch_scheduler #(
  parameter int TILES_PER_BATCH = 4,
  parameter int NUM_BATCHES     = 8,
  parameter int BATCH_ID_W      = 3,
  parameter int TILE_ID_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  tile_done,
  input  logic                  stream_busy,
  output logic                  tile_start,
  output logic [TILE_ID_W-1:0]  tile_id,
  output logic                  batch_complete,
  output logic [BATCH_ID_W-1:0] completed_batch_id,
  output logic                  all_batches_complete,
  output logic                  busy,
  output logic                  done,
  output logic                  err_spurious,
  output logic [2:0]            state_debug
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ISSUE       = 3'd1;
  localparam logic [2:0] S_WAIT_TILE   = 3'd2;
  localparam logic [2:0] S_BATCH_END   = 3'd3;
  localparam logic [2:0] S_GUARD       = 3'd4;
  localparam logic [2:0] S_GUARD_FINAL = 3'd5;
  localparam logic [2:0] S_WAIT_FINAL  = 3'd6;

  localparam int TIB_W = (TILES_PER_BATCH > 1) ? $clog2(TILES_PER_BATCH) : 1;
  localparam logic [TIB_W-1:0]      LAST_TILE  = TIB_W'(TILES_PER_BATCH - 1);
  localparam logic [BATCH_ID_W-1:0] LAST_BATCH = BATCH_ID_W'(NUM_BATCHES - 1);
  localparam logic [TIB_W-1:0]      TIB_ONE    = TIB_W'(1);
  localparam logic [BATCH_ID_W-1:0] BATCH_ONE  = BATCH_ID_W'(1);
  localparam logic [TILE_ID_W-1:0]  TID_ONE    = TILE_ID_W'(1);

  logic [2:0]            r_state;
  logic [TIB_W-1:0]      r_tile_in_batch;
  logic [BATCH_ID_W-1:0] r_batch_cnt;
  logic [TILE_ID_W-1:0]  r_tile_id;
  logic [BATCH_ID_W-1:0] r_completed_id;
  logic                  r_tile_start;
  logic                  r_batch_complete;
  logic                  r_all_complete;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic                  w_spurious;

  assign w_spurious = tile_done && (r_state != S_WAIT_TILE);

  // Sequencer FSM; pulse outputs default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_tile_in_batch  <= '0;
      r_batch_cnt      <= '0;
      r_tile_id        <= '0;
      r_completed_id   <= '0;
      r_tile_start     <= 1'b0;
      r_batch_complete <= 1'b0;
      r_all_complete   <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_err            <= 1'b0;
    end else begin
      r_tile_start     <= 1'b0;
      r_batch_complete <= 1'b0;
      r_all_complete   <= 1'b0;
      r_done           <= 1'b0;
      if (w_spurious) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state         <= S_ISSUE;
            r_busy          <= 1'b1;
            r_tile_in_batch <= '0;
            r_batch_cnt     <= '0;
            r_tile_id       <= '0;
            // A tile_done landing on the start cycle stays flagged for this run.
            r_err           <= tile_done;
          end
        end
        S_ISSUE: begin
          if (!stream_busy) begin
            r_tile_start <= 1'b1;
            r_state      <= S_WAIT_TILE;
          end
        end
        S_WAIT_TILE: begin
          if (tile_done) begin
            if (r_tile_in_batch == LAST_TILE) begin
              r_state <= S_BATCH_END;
            end else begin
              r_tile_in_batch <= r_tile_in_batch + TIB_ONE;
              r_tile_id       <= r_tile_id + TID_ONE;
              r_state         <= S_ISSUE;
            end
          end
        end
        S_BATCH_END: begin
          // The stream manager only samples triggers while it is idle.
          if (!stream_busy) begin
            r_completed_id <= r_batch_cnt;
            if (r_batch_cnt == LAST_BATCH) begin
              r_all_complete <= 1'b1;
              r_state        <= S_GUARD_FINAL;
            end else begin
              r_batch_complete <= 1'b1;
              r_state          <= S_GUARD;
            end
          end
        end
        S_GUARD: begin
          r_batch_cnt     <= r_batch_cnt + BATCH_ONE;
          r_tile_in_batch <= '0;
          r_tile_id       <= r_tile_id + TID_ONE;
          r_state         <= S_ISSUE;
        end
        S_GUARD_FINAL: begin
          r_state <= S_WAIT_FINAL;
        end
        S_WAIT_FINAL: begin
          if (!stream_busy) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign tile_start           = r_tile_start;
  assign tile_id              = r_tile_id;
  assign batch_complete       = r_batch_complete;
  assign completed_batch_id   = r_completed_id;
  assign all_batches_complete = r_all_complete;
  assign busy                 = r_busy;
  assign done                 = r_done;
  assign err_spurious         = r_err;
  assign state_debug          = r_state;

endmodule

// File: tb/tb_tile_batch_scheduler.sv
// Self-checking bench for tile_batch_scheduler: vector table, hand sequences and
// full runs checked against an event-timeline reference built from the block's rules.
module tb_tile_batch_scheduler;

  localparam int TPB = 4;
  localparam int NB  = 8;
  localparam int NC  = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, tile_done = 1'b0, stream_busy = 1'b0;
  logic       tile_start, batch_complete, all_batches_complete, busy, done, err_spurious;
  logic [4:0] tile_id;
  logic [2:0] completed_batch_id;
  logic [2:0] state_debug;

  int ntests = 0;
  int nfail  = 0;

  tile_batch_scheduler #(.TILES_PER_BATCH(TPB), .NUM_BATCHES(NB), .BATCH_ID_W(3), .TILE_ID_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .tile_done(tile_done), .stream_busy(stream_busy),
    .tile_start(tile_start), .tile_id(tile_id), .batch_complete(batch_complete),
    .completed_batch_id(completed_batch_id), .all_batches_complete(all_batches_complete),
    .busy(busy), .done(done), .err_spurious(err_spurious), .state_debug(state_debug)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int c, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, c, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " tile_start"}, 0, int'(tile_start), 0);
    chk({tag, " tile_id"}, 0, int'(tile_id), 0);
    chk({tag, " batch_complete"}, 0, int'(batch_complete), 0);
    chk({tag, " completed_id"}, 0, int'(completed_batch_id), 0);
    chk({tag, " all_complete"}, 0, int'(all_batches_complete), 0);
    chk({tag, " busy"}, 0, int'(busy), 0);
    chk({tag, " done"}, 0, int'(done), 0);
    chk({tag, " err"}, 0, int'(err_spurious), 0);
    chk({tag, " state"}, 0, int'(state_debug), 0);
  endtask

  // one clock: drive at negedge, observe 1 ns after the rising edge
  task automatic cyc(input logic s, input logic td, input logic sb);
    @(negedge clk);
    start = s; tile_done = td; stream_busy = sb;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; tile_done = 1'b0; stream_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic s, td, sb;
    logic ets;
    int   etid;
    logic ebc;
    int   ecid;
    logic ebusy, eerr;
    int   estate;
  } vec_t;

  // Reference timeline: per-edge stimulus and expected outputs after that edge.
  logic st_a[NC], td_a[NC], sb_a[NC];
  logic ets_a[NC], ebc_a[NC], eabc_a[NC], edone_a[NC], ebusy_a[NC];
  int   etid_a[NC], ecid_a[NC], tidset[NC], cidset[NC];
  int   end_c;

  function automatic int first_free(input int x);
    int y = x;
    while (y < NC - 1 && sb_a[y]) y++;
    return y;
  endfunction

  // mode 0: nominal (busy low, done 3 after start); 1: scripted stream; 2: random
  task automatic build(input int mode);
    int s, t, e, d, bb, de, g, burst;
    for (int c = 0; c < NC; c++) begin
      st_a[c] = 0; td_a[c] = 0; sb_a[c] = 0; ets_a[c] = 0; ebc_a[c] = 0;
      eabc_a[c] = 0; edone_a[c] = 0; ebusy_a[c] = 0; tidset[c] = -1; cidset[c] = -1;
    end
    burst = 0;
    if (mode == 2)
      for (int c = 0; c < NC; c++) begin
        if (burst > 0) begin sb_a[c] = 1; burst--; end
        else if ($urandom_range(0, 7) == 0) burst = $urandom_range(1, 6);
      end
    s = 2; st_a[s] = 1; tidset[s] = 0;
    t = s + 1; g = 0; de = s + 1;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < TPB; k++) begin
        e = first_free(t);
        ets_a[e] = 1;
        d = e + ((mode == 2) ? int'($urandom_range(1, 4)) : 3);
        if (d >= NC) d = NC - 1;
        td_a[d] = 1;
        if (k < TPB - 1) begin
          tidset[d] = g + 1; t = d + 1;
        end else begin
          bb = first_free(d + 1);
          cidset[bb] = b;
          if (b < NB - 1) ebc_a[bb] = 1; else eabc_a[bb] = 1;
          if (mode == 1 && b == 0)
            for (int c = bb + 2; c <= bb + 7 && c < NC; c++) sb_a[c] = 1;
          if (mode == 1 && b == NB - 1)
            for (int c = bb + 2; c <= bb + 101 && c < NC; c++) sb_a[c] = 1;
          if (b < NB - 1) begin
            if (bb + 1 < NC) tidset[bb + 1] = g + 1;
            t = bb + 2;
          end else begin
            de = first_free(bb + 2);
            edone_a[de] = 1;
          end
        end
        g++;
      end
    end
    for (int c = s; c < de; c++) ebusy_a[c] = 1;
    if (mode == 2)
      for (int c = s + 1; c <= de; c++) if ($urandom_range(0, 15) == 0) st_a[c] = 1;
    end_c = de + 3;
    if (end_c >= NC) begin
      chk("timeline_bound", 0, end_c, NC - 1);
      end_c = NC - 1;
    end
    for (int c = 0, tv = 0, cv = 0; c < NC; c++) begin
      if (tidset[c] >= 0) tv = tidset[c];
      if (cidset[c] >= 0) cv = cidset[c];
      etid_a[c] = tv; ecid_a[c] = cv;
    end
  endtask

  task automatic run_timeline(input string tag);
    do_reset();
    for (int c = 0; c <= end_c; c++) begin
      @(negedge clk);
      start = st_a[c]; tile_done = td_a[c]; stream_busy = sb_a[c];
      @(posedge clk);
      #1;
      chk({tag, " tile_start"}, c, int'(tile_start), int'(ets_a[c]));
      chk({tag, " tile_id"}, c, int'(tile_id), etid_a[c]);
      chk({tag, " batch_complete"}, c, int'(batch_complete), int'(ebc_a[c]));
      chk({tag, " all_complete"}, c, int'(all_batches_complete), int'(eabc_a[c]));
      chk({tag, " completed_id"}, c, int'(completed_batch_id), ecid_a[c]);
      chk({tag, " busy"}, c, int'(busy), int'(ebusy_a[c]));
      chk({tag, " done"}, c, int'(done), int'(edone_a[c]));
      chk({tag, " err"}, c, int'(err_spurious), 0);
    end
    start = 0; tile_done = 0; stream_busy = 0;
    chk({tag, " end_state"}, end_c, int'(state_debug), 0);
  endtask

  vec_t tbl[16];

  initial begin
    //            s  td sb   ts tid bc cid busy err state
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b1, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b1, 1'b1, 2};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 2};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1, 1'b1, 2};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1'b0, 0, 1'b1, 1'b1, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 0, 1'b1, 1'b1, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 0, 1'b1, 1'b1, 2};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 1'b0, 0, 1'b1, 1'b1, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 1'b0, 0, 1'b1, 1'b1, 2};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 1'b0, 0, 1'b1, 1'b1, 1};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0, 1'b1, 1'b1, 2};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 0, 1'b1, 1'b1, 3};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 3, 1'b0, 0, 1'b1, 1'b1, 3};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b1, 0, 1'b1, 1'b1, 4};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 0, 1'b1, 1'b1, 1};

    // reset state, checked while reset is still asserted
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // spurious inputs, stall and trigger hold-off
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].s, tbl[i].td, tbl[i].sb);
      chk("tbl tile_start", i, int'(tile_start), int'(tbl[i].ets));
      chk("tbl tile_id", i, int'(tile_id), tbl[i].etid);
      chk("tbl batch_complete", i, int'(batch_complete), int'(tbl[i].ebc));
      chk("tbl completed_id", i, int'(completed_batch_id), tbl[i].ecid);
      chk("tbl busy", i, int'(busy), int'(tbl[i].ebusy));
      chk("tbl err", i, int'(err_spurious), int'(tbl[i].eerr));
      chk("tbl state", i, int'(state_debug), tbl[i].estate);
    end

    // carry on into batch 2 WAIT_TILE, then reset asynchronously
    cyc(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0);
      chk("seq tile_start", k, int'(tile_start), 1);
      chk("seq tile_id", k, int'(tile_id), 5 + k);
    end
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("seq batch1 pulse", 0, int'(batch_complete), 1);
    chk("seq batch1 id", 0, int'(completed_batch_id), 1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("seq tile8 start", 0, int'(tile_start), 1);
    chk("seq tile8 id", 0, int'(tile_id), 8);
    chk("seq wait state", 0, int'(state_debug), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // start coinciding with tile_done: taken, flagged spurious
    cyc(1'b1, 1'b1, 1'b0);
    chk("coinc state", 0, int'(state_debug), 1);
    chk("coinc err", 0, int'(err_spurious), 1);
    chk("coinc tile_id", 0, int'(tile_id), 0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("restart tile_start", 0, int'(tile_start), 1);
    chk("restart tile_id", 0, int'(tile_id), 0);
    chk("restart completed_id", 0, int'(completed_batch_id), 0);
    chk("restart err", 0, int'(err_spurious), 1);

    build(0);
    run_timeline("nominal");
    build(1);
    run_timeline("stream");
    for (int r = 0; r < 3; r++) begin
      build(2);
      run_timeline("random");
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
